// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: arbitrates a CPU core and a debug loader onto one single-port memory bus
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_cpu_req/we/addr/wdata         CPU transfer request (level), direction, word address, write data
//   i_dbg_req/we/addr/wdata         debug loader transfer request, same meaning
//   o_cpu_ack, o_dbg_ack            one-cycle transfer-complete pulse to the winning requester
//   o_rdata                         registered read data shared by both requesters
//   o_mem_addr, o_mem_wdata         memory address / write data (from the latched request)
//   o_mem_re, o_mem_we              memory strobes, only during ACCESS and never together
//   i_mem_rdata                     memory read data, captured on the last ACCESS edge
//   o_busy                          high whenever the FSM is not IDLE
// Optional: define ARB_ROUND_ROBIN_EN to alternate simultaneous grants; otherwise DBG always wins.
module memory_bus_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic [15:0] i_dbg_addr,
    input  logic [15:0] i_dbg_wdata,
    output logic        o_cpu_ack,
    output logic        o_dbg_ack,
    output logic [15:0] o_rdata,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_re,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);
    state_t      r_state, w_next;
    logic [2:0]  r_cnt;
    logic        r_dbg, r_we;
    logic [15:0] r_addr, r_wdata, r_rdata;
    logic        w_req, w_grant_dbg, w_dbg_pri, w_last, w_start;
`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dbg;
    // last grant resets to CPU, so the first contested grant goes to DBG
    always_ff @(posedge i_clk) begin
        if (i_reset) r_last_dbg <= 1'b0;
        else if (w_start) r_last_dbg <= w_grant_dbg;
    end
    assign w_dbg_pri = ~r_last_dbg;
`else
    assign w_dbg_pri = 1'b1;
`endif
    assign w_req       = i_cpu_req | i_dbg_req;
    assign w_start     = (r_state == IDLE) && w_req;
    assign w_grant_dbg = i_dbg_req & (~i_cpu_req | w_dbg_pri);
    assign w_last      = r_cnt == LAST_CNT;
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE) w_next = w_req ? ACCESS : IDLE;
        else if (r_state == ACCESS) w_next = w_last ? ACK : ACCESS;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= 3'd0;
            r_dbg   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
        end else begin
            if (w_start) begin
                r_cnt   <= 3'd0;
                r_dbg   <= w_grant_dbg;
                r_we    <= w_grant_dbg ? i_dbg_we : i_cpu_we;
                r_addr  <= w_grant_dbg ? i_dbg_addr : i_cpu_addr;
                r_wdata <= w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
            end
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 3'd1;
                if (w_last && !r_we) r_rdata <= i_mem_rdata;
            end
        end
    end
    assign o_busy      = r_state != IDLE;
    assign o_mem_re    = (r_state == ACCESS) && !r_we;
    assign o_mem_we    = (r_state == ACCESS) && r_we;
    assign o_cpu_ack   = (r_state == ACK) && !r_dbg;
    assign o_dbg_ack   = (r_state == ACK) && r_dbg;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: scoreboard bench for memory_bus_arbiter at WAIT_STATES 1, 0 and 3
module tb_memory_bus_arbiter;
    typedef struct {
        int          g;
        bit          dbg;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [2:0]  cpu_req = '0, cpu_we = '0, dbg_req = '0, dbg_we = '0;
    logic [15:0] cpu_addr [3], cpu_wdata [3], dbg_addr [3], dbg_wdata [3];
    logic [2:0]  cpu_ack, dbg_ack, mem_re, mem_we, busy;
    logic [15:0] rdata [3], mem_addr [3], mem_wdata [3], mem_rdata [3];
    int          checks = 0, errors = 0, cyc = 0;
    int          re_cnt [3], we_cnt [3];
    logic [15:0] wr_addr [3], wr_data [3];
    exp_t        q [$];
    exp_t        mon_e;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        memory_bus_arbiter #(.WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))) dut (
            .i_clk(clk), .i_reset(rst[g]),
            .i_cpu_req(cpu_req[g]), .i_cpu_we(cpu_we[g]), .i_cpu_addr(cpu_addr[g]), .i_cpu_wdata(cpu_wdata[g]),
            .i_dbg_req(dbg_req[g]), .i_dbg_we(dbg_we[g]), .i_dbg_addr(dbg_addr[g]), .i_dbg_wdata(dbg_wdata[g]),
            .o_cpu_ack(cpu_ack[g]), .o_dbg_ack(dbg_ack[g]), .o_rdata(rdata[g]),
            .o_mem_addr(mem_addr[g]), .o_mem_wdata(mem_wdata[g]), .o_mem_re(mem_re[g]), .o_mem_we(mem_we[g]),
            .i_mem_rdata(mem_rdata[g]), .o_busy(busy[g])
        );
        // memory model: one fixed word, everything else derived from the address
        assign mem_rdata[g] = (mem_addr[g] == 16'h1234) ? 16'hBEEF : (mem_addr[g] ^ 16'h5A5A);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_acks(input int g, input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            tick(1);
            if (cpu_ack[g] | dbg_ack[g]) seen++;
        end
        chk("ack_count_within_budget", seen, n);
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ((mem_re[k] & mem_we[k]) | ((mem_re[k] | mem_we[k]) & ~busy[k]) | (cpu_ack[k] & dbg_ack[k])) begin
                errors++;
                $display("FAIL bus_exclusive inst %0d: re=%b we=%b busy=%b cpu_ack=%b dbg_ack=%b",
                         k, mem_re[k], mem_we[k], busy[k], cpu_ack[k], dbg_ack[k]);
            end
            if (mem_re[k]) re_cnt[k]++;
            if (mem_we[k]) begin
                we_cnt[k]++;
                wr_addr[k] = mem_addr[k];
                wr_data[k] = mem_wdata[k];
            end
            if (cpu_ack[k] | dbg_ack[k]) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack inst %0d: cpu_ack=%b dbg_ack=%b at cycle %0d, required none", k, cpu_ack[k], dbg_ack[k], cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("ack_instance", k, mon_e.g);
                    chk("ack_is_dbg", dbg_ack[k], mon_e.dbg);
                    chk("ack_rdata", rdata[k], mon_e.rdata);
                    chk("ack_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end
    initial begin
        int c0, r0, w0;
        for (int k = 0; k < 3; k++) begin
            cpu_addr[k] = '0; cpu_wdata[k] = '0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
        end
        tick(2);
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", busy[k], 0);
            chk("reset_rdata", rdata[k], 0);
            chk("reset_mem_addr", mem_addr[k], 0);
            chk("reset_acks", {cpu_ack[k], dbg_ack[k]}, 0);
        end
        rst = 3'b000;
        tick(1);
        // WAIT_STATES=1: CPU read of 0x1234
        r0 = re_cnt[0];
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h1234;
        c0 = cyc;
        q.push_back('{0, 1'b0, 16'hBEEF, c0 + 3});
        wait_acks(0, 1, 10);
        cpu_req[0] = 0;
        tick(2);
        chk("read_re_cycles", re_cnt[0] - r0, 2);
        // WAIT_STATES=0: DBG write 0x00FF <- 0xA5A5
        r0 = re_cnt[1];
        w0 = we_cnt[1];
        dbg_req[1] = 1; dbg_we[1] = 1; dbg_addr[1] = 16'h00FF; dbg_wdata[1] = 16'hA5A5;
        c0 = cyc;
        q.push_back('{1, 1'b1, 16'h0000, c0 + 2});
        wait_acks(1, 1, 10);
        dbg_req[1] = 0;
        tick(2);
        chk("write_we_cycles", we_cnt[1] - w0, 1);
        chk("write_re_cycles", re_cnt[1] - r0, 0);
        chk("write_addr", wr_addr[1], 16'h00FF);
        chk("write_data", wr_data[1], 16'hA5A5);
        // WAIT_STATES=1: both requesters held for four transfers
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h0100;
        dbg_req[0] = 1; dbg_we[0] = 1; dbg_addr[0] = 16'h0200; dbg_wdata[0] = 16'h1111;
        c0 = cyc;
`ifdef ARB_ROUND_ROBIN_EN
        q.push_back('{0, 1'b1, 16'hBEEF, c0 + 3});
        q.push_back('{0, 1'b0, 16'h5B5A, c0 + 7});
        q.push_back('{0, 1'b1, 16'h5B5A, c0 + 11});
        q.push_back('{0, 1'b0, 16'h5B5A, c0 + 15});
`else
        q.push_back('{0, 1'b1, 16'hBEEF, c0 + 3});
        q.push_back('{0, 1'b1, 16'hBEEF, c0 + 7});
        q.push_back('{0, 1'b1, 16'hBEEF, c0 + 11});
        q.push_back('{0, 1'b1, 16'hBEEF, c0 + 15});
`endif
        wait_acks(0, 4, 30);
        cpu_req[0] = 0; dbg_req[0] = 0;
        tick(2);
        // CPU request withdrawn during the first ACCESS cycle still completes once
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h0300;
        c0 = cyc;
        q.push_back('{0, 1'b0, 16'h595A, c0 + 3});
        tick(1);
        cpu_req[0] = 0;
        wait_acks(0, 1, 10);
        tick(4);
        chk("dropped_req_idle", busy[0], 0);
        // WAIT_STATES=3: a completed read, then reset during a second read
        cpu_req[2] = 1; cpu_we[2] = 0; cpu_addr[2] = 16'h1234;
        c0 = cyc;
        q.push_back('{2, 1'b0, 16'hBEEF, c0 + 5});
        wait_acks(2, 1, 12);
        cpu_req[2] = 0;
        tick(2);
        chk("ws3_rdata_before_reset", rdata[2], 16'hBEEF);
        cpu_req[2] = 1; cpu_addr[2] = 16'h0400;
        tick(3);
        chk("ws3_in_access", {busy[2], mem_re[2]}, 2'b11);
        rst[2] = 1; cpu_req[2] = 0;
        tick(1);
        rst[2] = 0;
        chk("abort_strobes", {mem_re[2], mem_we[2]}, 0);
        chk("abort_busy", busy[2], 0);
        chk("abort_rdata", rdata[2], 0);
        chk("abort_acks", {cpu_ack[2], dbg_ack[2]}, 0);
        tick(8);
        chk("abort_still_idle", busy[2], 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, extra ACCESS cycles per transfer (legal 0..7).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports CPU_REQ / DBG_REQ  input  1  level transfer request from CPU core / debug loader.
REQ-005 SHALL have ports CPU_WE / DBG_WE  input  1  1=write, 0=read; held stable with REQ.
REQ-006 SHALL have ports CPU_ADDR / DBG_ADDR  input  16  requester word address.
REQ-007 SHALL have ports CPU_WDATA / DBG_WDATA  input  16  requester write data.
REQ-008 SHALL have ports CPU_ACK / DBG_ACK  output  1  one-cycle transfer-complete pulse.
REQ-009 SHALL have port RDATA  output  16  registered read data, shared by both requesters.
REQ-010 SHALL have ports MEM_ADDR, MEM_WDATA  output  16  memory address / write data.
REQ-011 SHALL have ports MEM_RE, MEM_WE  output  1  memory strobes.
REQ-012 SHALL have port MEM_RDATA  input  16  memory read data.
REQ-013 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCESS, ACK.
REQ-015 IDLE: no strobes; if any REQ high, SHALL latch winner, its ADDR/WDATA/WE, and enter ACCESS next edge; else stay IDLE.
REQ-016 ACCESS: MEM_ADDR/MEM_WDATA SHALL come from latched values; MEM_WE=latched WE, MEM_RE=!latched WE; state lasts exactly WAIT_STATES+1 cycles, counted by 3-bit counter.
REQ-017 On final ACCESS cycle's edge, read transfers SHALL register MEM_RDATA into RDATA; writes SHALL leave RDATA unchanged.
REQ-018 ACK: winner's ACK high for exactly one cycle, strobes low; then IDLE.
REQ-019 Latency: REQ high in IDLE at edge n -> ACK high in cycle n+2+WAIT_STATES; RDATA valid in ACK cycle, held until next read completes.
REQ-020 Requests SHALL be sampled only in IDLE; REQ changes in ACCESS/ACK ignored.
REQ-021 REQ dropped mid-transfer SHALL NOT abort; transfer completes and ACK still pulses.
REQ-022 REQ still high in IDLE after ACK SHALL start a new transfer (one ACK per transfer).
REQ-023 Both REQ high in IDLE: winner per Configuration; loser waits, no ACK.
REQ-024 MEM_RE and MEM_WE SHALL never be high together; both low outside ACCESS.
REQ-025 Minimum transfer period SHALL be WAIT_STATES+3 cycles (IDLE, ACCESS, ACK).

Reset
REQ-026 RESET high at an edge SHALL force IDLE, counter 0, RDATA 0, all ACKs, strobes, BUSY 0, MEM_ADDR/MEM_WDATA 0, last-grant = CPU.
REQ-027 RESET mid-ACCESS SHALL abort: strobes low after that edge, no ACK issued for the aborted transfer.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL go to requester not granted last; last-grant updates on each IDLE->ACCESS.
REQ-029 Macro undefined: DBG SHALL always win simultaneous requests; last-grant register absent; CPU starvation under continuous DBG_REQ is permitted.

Verification
REQ-030 WAIT_STATES=1, CPU read 0x1234, MEM_RDATA=0xBEEF -> MEM_RE high 2 cycles, CPU_ACK pulses 3 cycles after request edge, RDATA=0xBEEF.
REQ-031 WAIT_STATES=0, DBG write 0x00FF<-0xA5A5 -> MEM_WE one cycle with MEM_ADDR=0x00FF, MEM_WDATA=0xA5A5, DBG_ACK next cycle, RDATA unchanged.
REQ-032 Both REQ held high 4 transfers -> RR: DBG,CPU,DBG,CPU; fixed: DBG x4, no CPU_ACK.
REQ-033 CPU_REQ dropped in first ACCESS cycle -> transfer completes, single CPU_ACK, then IDLE.
REQ-034 RESET during ACCESS (WAIT_STATES=3) -> strobes low, BUSY 0 next cycle, no ACK, RDATA 0.
